// File: rtl/glyph_pkg.sv
// glyph_pkg: shared definitions for the glyph plotter.
//   state_t       - plotter FSM states (idle, drawing pixels, completion)
//   *_DEF         - default glyph geometry, screen bounds and colour width
package glyph_pkg;

  localparam int unsigned GLYPH_W_DEF  = 8;
  localparam int unsigned GLYPH_H_DEF  = 16;
  localparam int unsigned X_LIMIT_DEF  = 640;
  localparam int unsigned Y_LIMIT_DEF  = 480;
  localparam int unsigned COLOUR_W_DEF = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/glyph_shift_reg.sv
// glyph_shift_reg: parallel-load, MSB-first shift register holding the glyph bitmap.
//   clk, reset - clock, asynchronous active-high reset
//   load       - capture data (takes priority over shift)
//   shift      - move the next bit into the MSB position
//   data       - glyph bitmap to load
//   msb        - current glyph bit
module glyph_shift_reg #(
  parameter int unsigned WIDTH = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
  output logic             msb
);

  logic [WIDTH-1:0] bits;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bits <= '0;
    end else if (load) begin
      bits <= data;
    end else if (shift) begin
      bits <= bits << 1;
    end
  end

  assign msb = bits[WIDTH-1];

endmodule

// File: rtl/glyph_plotter.sv
// glyph_plotter: draws a GLYPH_W x GLYPH_H bitmap glyph one pixel per cycle.
//   clk, reset               - clock, asynchronous active-high reset
//   req_valid / req_ready    - request handshake (ready only when idle)
//   req_x, req_y             - top-left corner of the cell
//   req_glyph                - bitmap, MSB is top-left pixel, row-major
//   req_fg, req_bg           - foreground / background colour
//   req_transparent          - only with GLYPH_PLOTTER_TRANSPARENT_EN: skip zero pixels
//   plot, x_out, y_out,
//   colour_out               - pixel-write strobe and pixel data
//   busy, done               - drawing in progress / one-cycle completion pulse
// Optional feature macro: GLYPH_PLOTTER_TRANSPARENT_EN.
module glyph_plotter
  import glyph_pkg::*;
#(
  parameter int unsigned GLYPH_W  = GLYPH_W_DEF,
  parameter int unsigned GLYPH_H  = GLYPH_H_DEF,
  parameter int unsigned X_W      = 10,
  parameter int unsigned Y_W      = 9,
  parameter int unsigned X_LIMIT  = X_LIMIT_DEF,
  parameter int unsigned Y_LIMIT  = Y_LIMIT_DEF,
  parameter int unsigned COLOUR_W = COLOUR_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [X_W-1:0]             req_x,
  input  logic [Y_W-1:0]             req_y,
  input  logic [GLYPH_W*GLYPH_H-1:0] req_glyph,
  input  logic [COLOUR_W-1:0]        req_fg,
  input  logic [COLOUR_W-1:0]        req_bg,
`ifdef GLYPH_PLOTTER_TRANSPARENT_EN
  input  logic                       req_transparent,
`endif
  output logic                       plot,
  output logic [X_W-1:0]             x_out,
  output logic [Y_W-1:0]             y_out,
  output logic [COLOUR_W-1:0]        colour_out,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned NPIX = GLYPH_W * GLYPH_H;
  localparam int unsigned CW   = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam int unsigned RW   = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;

  state_t              state;
  logic                armed;  // keeps req_ready low until the first edge after reset
  logic [X_W-1:0]      x_base;
  logic [Y_W-1:0]      y_base;
  logic [COLOUR_W-1:0] fg, bg;
  logic [CW-1:0]       col;
  logic [RW-1:0]       row;
  logic [X_W-1:0]      x_hold;
  logic [Y_W-1:0]      y_hold;
  logic [COLOUR_W-1:0] c_hold;
`ifdef GLYPH_PLOTTER_TRANSPARENT_EN
  logic                transp;
`endif

  logic                transfer, drawing, last_pix, pix, show, in_bounds;
  logic [X_W:0]        x_wide;
  logic [Y_W:0]        y_wide;
  logic [COLOUR_W-1:0] colour_cur;

  assign drawing   = (state == S_DRAW);
  assign req_ready = (state == S_IDLE) && armed;
  assign transfer  = req_valid && req_ready;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign last_pix  = (col == CW'(GLYPH_W - 1)) && (row == RW'(GLYPH_H - 1));

  glyph_shift_reg #(
    .WIDTH(NPIX)
  ) u_shift (
    .clk  (clk),
    .reset(reset),
    .load (transfer),
    .shift(drawing),
    .data (req_glyph),
    .msb  (pix)
  );

  // One extra bit so coordinates past the screen edge are clipped instead of wrapping.
  assign x_wide     = {1'b0, x_base} + (X_W + 1)'(col);
  assign y_wide     = {1'b0, y_base} + (Y_W + 1)'(row);
  assign in_bounds  = (x_wide < (X_W + 1)'(X_LIMIT)) && (y_wide < (Y_W + 1)'(Y_LIMIT));
  assign colour_cur = pix ? fg : bg;
`ifdef GLYPH_PLOTTER_TRANSPARENT_EN
  assign show = pix || !transp;
`else
  assign show = 1'b1;
`endif

  assign plot       = drawing && in_bounds && show;
  assign x_out      = drawing ? x_wide[X_W-1:0] : x_hold;
  assign y_out      = drawing ? y_wide[Y_W-1:0] : y_hold;
  assign colour_out = drawing ? colour_cur : c_hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      armed  <= 1'b0;
      x_base <= '0;
      y_base <= '0;
      fg     <= '0;
      bg     <= '0;
      col    <= '0;
      row    <= '0;
      x_hold <= '0;
      y_hold <= '0;
      c_hold <= '0;
`ifdef GLYPH_PLOTTER_TRANSPARENT_EN
      transp <= 1'b0;
`endif
    end else begin
      armed <= 1'b1;
      case (state)
        S_IDLE: begin
          if (transfer) begin
            x_base <= req_x;
            y_base <= req_y;
            fg     <= req_fg;
            bg     <= req_bg;
`ifdef GLYPH_PLOTTER_TRANSPARENT_EN
            transp <= req_transparent;
`endif
            col    <= '0;
            row    <= '0;
            state  <= S_DRAW;
          end
        end
        S_DRAW: begin
          x_hold <= x_wide[X_W-1:0];
          y_hold <= y_wide[Y_W-1:0];
          c_hold <= colour_cur;
          if (last_pix) begin
            state <= S_DONE;
          end else if (col == CW'(GLYPH_W - 1)) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
